// File: rtl/hamm_weight_gen_pkg.sv
// Shared constants for the fixed-weight word generator.
// State codes, clog2 and central binomial table.
package hamm_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // C(w, w/2): largest word count for width w
  function automatic int cmid(input int w);
    int r;
    case (w)
      4:       r = 6;
      5:       r = 10;
      6:       r = 20;
      7:       r = 35;
      8:       r = 70;
      9:       r = 126;
      10:      r = 252;
      11:      r = 462;
      12:      r = 924;
      13:      r = 1716;
      14:      r = 3432;
      15:      r = 6435;
      16:      r = 12870;
      default: r = 12870;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hamm_weight_gen_if.sv
// Output stream bundle of the fixed-weight generator.
// Valid/ready with a last marker.
interface hamm_weight_gen_if #(
  parameter int W = 8
);
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/hamm_weight_gen_next.sv
// Gosper successor: next larger word of equal popcount.
// Divide replaced by a trailing-zero shift.
module hamm_next
  import hamm_pkg::*;
#(
  parameter  int W  = 8,
  localparam int KW = clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  nxt,
  output logic          nxt_is_top
);

  logic [W-1:0]  lowest;
  logic [W-1:0]  ripple;
  logic [W-1:0]  ones;
  logic [W-1:0]  top;
  logic [KW-1:0] tz;

  // trailing-zero count of x, i.e. log2 of the lowest set bit
  always_comb begin
    tz = '0;
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) tz = KW'(i);
  end

  // successor and top-pattern detection
  always_comb begin
    lowest     = x & (~x + 1'b1);
    ripple     = x + lowest;
    ones       = ((x ^ ripple) >> 2) >> tz;
    nxt        = ripple | ones;
    top        = ~({W{1'b1}} >> k);
    nxt_is_top = (nxt == top);
  end

endmodule

// File: rtl/hamm_weight_gen.sv
// Streams every W-bit word of popcount k in ascending order.
// Two-state FSM with registered outputs and a word counter.
module hamm_weight_gen
  import hamm_pkg::*;
#(
  parameter  int W  = 8,
  localparam int KW = clog2(W + 1),
  localparam int CW = clog2(cmid(W) + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       weight,
  input  logic                abort,
  hamm_weight_gen_if.master   out,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CW-1:0]       count
);

  logic [0:0]    state;
  logic [KW-1:0] k_q;
  logic [W-1:0]  nxt;
  logic          nxt_top;
  logic [W-1:0]  low;
  logic          bad_k;
  logic          edge_k;
  logic          xfer;

  hamm_next #(.W(W)) u_next (
    .x          (out.out_data),
    .k          (k_q),
    .nxt        (nxt),
    .nxt_is_top (nxt_top)
  );

  // start decode: first word, range check, single-word cases
  always_comb begin
    low    = ~({W{1'b1}} << weight);
    bad_k  = int'(weight) > W;
    edge_k = (weight == '0) || (int'(weight) == W);
    xfer   = out.out_valid && out.out_ready;
  end

  // FSM, output registers and accepted-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      k_q           <= '0;
      out.out_data  <= '0;
      out.out_valid <= 1'b0;
      out.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      count         <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (bad_k) begin
              err <= 1'b1;
            end else begin
              state         <= ST_RUN;
              k_q           <= weight;
              busy          <= 1'b1;
              out.out_valid <= 1'b1;
              out.out_data  <= low;
              out.out_last  <= edge_k;
              count         <= '0;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state         <= ST_IDLE;
            out.out_valid <= 1'b0;
            out.out_last  <= 1'b0;
            busy          <= 1'b0;
          end else if (xfer) begin
            count <= count + CW'(1);
            if (out.out_last) begin
              state         <= ST_IDLE;
              out.out_valid <= 1'b0;
              out.out_last  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              out.out_data <= nxt;
              out.out_last <= nxt_top;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamm_weight_gen.sv
// Directed bench for hamm_weight_gen at W=8.
// Brute-force successor model, hand-picked words.
module tb_hamm_weight_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] weight = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] count;

  int checks = 0;
  int failures = 0;
  int seen[$];
  int n;

  hamm_weight_gen_if #(.W(8)) bus ();

  hamm_weight_gen #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .weight (weight),
    .abort  (abort),
    .out    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_next(input int x, input int k);
    for (int v = x + 1; v < 256; v++)
      if ($countones(v) == k) return v;
    return -1;
  endfunction

  // run one enumeration; abort_at < 0 means never abort
  task automatic stream(input int k, input bit stall,
                        input int abort_at, output int got);
    int exp, nx, cyc;
    bit r, fin, ab;
    exp = (1 << k) - 1;
    got = 0;
    fin = 0;
    cyc = 0;
    seen.delete();
    weight = 4'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_count", int'(count), 0);
    while (!fin && cyc < 1000) begin
      nx = ref_next(exp, k);
      chk("valid", int'(bus.out_valid), 1);
      chk("busy", int'(busy), 1);
      chk("data", int'(bus.out_data), exp);
      chk("last", int'(bus.out_last), int'(nx < 0));
      chk("popcount", $countones(bus.out_data), k);
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ab = (got == abort_at);
      bus.out_ready = r;
      abort = ab;
      tick();
      abort = 1'b0;
      if (ab) begin
        fin = 1;
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
      end else if (r) begin
        seen.push_back(exp);
        got++;
        if (nx < 0) begin
          fin = 1;
          chk("done", int'(done), 1);
          chk("end_valid", int'(bus.out_valid), 0);
          chk("end_busy", int'(busy), 0);
        end else begin
          exp = nx;
        end
      end
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (!fin) chk("stream_timeout", 0, 1);
    chk("count", int'(count), got);
    tick();
    chk("done_pulse_end", int'(done), 0);
    chk("count_hold", int'(count), got);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    tick();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    stream(2, 1'b0, -1, n);
    chk("k2_n", n, 28);
    chk("k2_w0", seen[0], 'h03);
    chk("k2_w1", seen[1], 'h05);
    chk("k2_w2", seen[2], 'h06);
    chk("k2_w3", seen[3], 'h09);
    chk("k2_w6", seen[6], 'h11);
    chk("k2_wlast", seen[27], 'hC0);

    stream(0, 1'b0, -1, n);
    chk("k0_n", n, 1);
    chk("k0_w", seen[0], 'h00);
    stream(8, 1'b0, -1, n);
    chk("k8_n", n, 1);
    chk("k8_w", seen[0], 'hFF);

    weight = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_valid", int'(bus.out_valid), 0);
    chk("err_busy", int'(busy), 0);
    chk("err_count", int'(count), 1);
    tick();
    chk("err_clear", int'(err), 0);

    stream(4, 1'b1, -1, n);
    chk("k4_n", n, 70);
    chk("k4_count", int'(count), 70);
    chk("k4_first", seen[0], 'h0F);
    chk("k4_last", seen[69], 'hF0);

    stream(3, 1'b0, 10, n);
    chk("abort_n", n, 10);
    chk("abort_count", int'(count), 10);

    stream(1, 1'b0, -1, n);
    chk("k1_n", n, 8);
    chk("k1_first", seen[0], 'h01);
    chk("k1_last", seen[7], 'h80);

    weight = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_data", int'(bus.out_data), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_last", int'(bus.out_last), 0);
    tick();
    rst_n = 1'b1;
    tick();
    stream(5, 1'b0, -1, n);
    chk("k5_n", n, 56);
    chk("k5_first", seen[0], 'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
